// File: rtl/lane_ram.sv
// lane_ram: byte-lane RAM with per-lane chip select / write enable, a common
// read enable, registered read data and a power-on clear sequence that zeroes
// every word before the array accepts traffic.
// Optional per-lane even parity is enabled by defining LANE_RAM_PARITY_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing the array, one word per cycle; busy=1, ports ignored
// ST_IDLE  | normal lane-wise read/write service; busy=0
module lane_ram #(
  parameter int LANES  = 2,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         a,
  input  logic [LANES-1:0]          cs,
  input  logic [LANES-1:0]          we,
  input  logic                      oe,
  input  logic [LANES*LANE_W-1:0]   wdata,
  output logic [LANES*LANE_W-1:0]   rdata,
  output logic                      rvalid,
  output logic                      busy,
  output logic                      perr
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]              state;
  logic [ADDR_W-1:0]       clr_cnt;
  logic [LANES-1:0]        wr_lane;
  logic [LANES-1:0]        rd_lane;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LANES*LANE_W-1:0] mem_wdata;
  logic [LANES*LANE_W-1:0] rd_word;

  logic [LANE_W-1:0] mem [LANES][DEPTH];

  assign busy = (state == ST_CLEAR);

  // Per-lane access decode; CLEAR forces a zero write to every lane at the counter address.
  always_comb begin
    wr_lane   = '0;
    rd_lane   = '0;
    mem_addr  = a;
    mem_wdata = wdata;
    if (state == ST_CLEAR) begin
      mem_addr  = clr_cnt;
      mem_wdata = '0;
      wr_lane   = rst_n ? {LANES{1'b1}} : '0;
    end else if (rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        wr_lane[k] = cs[k] & we[k] & ~oe;
        rd_lane[k] = cs[k] & ~we[k] & oe;
      end
    end
  end

  // Read word assembly: selected lanes carry array data, unread lanes are zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (rd_lane[k]) rd_word[k*LANE_W +: LANE_W] = mem[k][mem_addr];
    end
  end

  // Sequencer: CLEAR walks every address once; the counter wraps to 0 as it leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == {ADDR_W{1'b1}}) state <= ST_IDLE;
    end
  end

  // Array write port; the contents are never reset directly, only zeroed by CLEAR.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_lane[k]) mem[k][mem_addr] <= mem_wdata[k*LANE_W +: LANE_W];
    end
  end

  // Registered read data; rdata holds its last value when nothing is read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= |rd_lane;
      if (|rd_lane) rdata <= rd_word;
    end
  end

`ifdef LANE_RAM_PARITY_EN
  logic              par [LANES][DEPTH];
  logic [LANES-1:0]  rd_mis;

  // Parity check for each lane being read, against the bit stored with it.
  always_comb begin
    rd_mis = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_mis[k] = rd_lane[k] & ((^mem[k][mem_addr]) != par[k][mem_addr]);
    end
  end

  // Parity store; CLEAR writes zero data with its matching zero parity.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_lane[k]) par[k][mem_addr] <= ^mem_wdata[k*LANE_W +: LANE_W];
    end
  end

  // Parity error pulse, aligned with rvalid.
  always_ff @(posedge clk) begin
    if (!rst_n) perr <= 1'b0;
    else        perr <= |rd_mis;
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_lane_ram.sv
// Bench for lane_ram (defaults LANES=2, LANE_W=8, ADDR_W=8): directed scenarios
// followed by random traffic, all checked against a word-level array model.
module tb_lane_ram;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [1:0]  cs;
  logic [1:0]  we;
  logic        oe;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        perr;

  lane_ram #(.LANES(2), .LANE_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .cs(cs), .we(we), .oe(oe),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .busy(busy), .perr(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model state
  logic [15:0] mm [256];
  logic [15:0] exp_rdata = '0;
  logic        exp_rvalid = 1'b0;
  logic        exp_busy = 1'b1;
  logic        exp_perr = 1'b0;
  int          clear_left = 256;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic cyc(input logic r, input logic [1:0] c, input logic [1:0] w,
                     input logic o, input logic [7:0] ad, input logic [15:0] wd);
    logic        rd;
    logic [15:0] nxt;
    rst_n = r; cs = c; we = w; oe = o; a = ad; wdata = wd;
    if (!r) begin
      exp_rdata  = '0;
      exp_rvalid = 1'b0;
      clear_left = 256;
      for (int i = 0; i < 256; i++) mm[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_rvalid = 1'b0;
    end else begin
      rd  = 1'b0;
      nxt = '0;
      for (int k = 0; k < 2; k++) begin
        if (c[k] && o && !w[k]) begin
          rd = 1'b1;
          nxt[k*8 +: 8] = mm[ad][k*8 +: 8];
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (c[k] && w[k] && !o) mm[ad][k*8 +: 8] = wd[k*8 +: 8];
      end
      exp_rvalid = rd;
      if (rd) exp_rdata = nxt;
    end
    exp_busy = (clear_left > 0);
    @(posedge clk);
    #1;
    chk("busy", busy, exp_busy);
    chk("rvalid", rvalid, exp_rvalid);
    chk("rdata", rdata, exp_rdata);
    chk("perr", perr, exp_perr);
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 16'h0000);
  endtask

  // Runs until busy drops, bounded; returns the number of busy cycles seen.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 1000) begin
      if (n == 10) cyc(1'b1, 2'b11, 2'b11, 1'b0, 8'h05, 16'hFFFF);
      else if (n == 20) cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'h05, 16'h0000);
      else idle_cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [1:0]  rc, rw;
    logic        ro;
    logic [7:0]  ra;
    logic [15:0] rwd;

    rst_n = 1'b0; cs = '0; we = '0; oe = 1'b0; a = '0; wdata = '0;
    for (int i = 0; i < 256; i++) mm[i] = '0;

    cyc(1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 16'h0000);
    cyc(1'b0, 2'b11, 2'b00, 1'b1, 8'h00, 16'h0000);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_busy", busy, 1'b1);

    wait_clear(n);
    chk("clear_len", n, 256);

    // reads after clear, including the address hit while busy
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'h05, 16'h0000);
    chk("busy_write_ignored", rdata, 16'h0000);
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'hFF, 16'h0000);
    chk("clear_ff", rdata, 16'h0000);
    chk("clear_perr", perr, 1'b0);

    // full-word write, read back next cycle
    cyc(1'b1, 2'b11, 2'b11, 1'b0, 8'h10, 16'hA55A);
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'h10, 16'h0000);
    chk("word_rd", rdata, 16'hA55A);
    chk("word_rv", rvalid, 1'b1);
    idle_cyc();
    chk("rv_pulse", rvalid, 1'b0);
    chk("rdata_hold", rdata, 16'hA55A);

    // lane-wise writes and reads
    cyc(1'b1, 2'b01, 2'b01, 1'b0, 8'h20, 16'h00C3);
    cyc(1'b1, 2'b10, 2'b10, 1'b0, 8'h20, 16'h7E00);
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 8'h20, 16'h0000);
    chk("lane0_rd", rdata, 16'h00C3);
    cyc(1'b1, 2'b10, 2'b00, 1'b1, 8'h20, 16'h0000);
    chk("lane1_rd", rdata, 16'h7E00);

    // oe with we on lane1: lane1 does nothing, lane0 read
    cyc(1'b1, 2'b11, 2'b10, 1'b1, 8'h10, 16'hFFFF);
    chk("mixed_rd", rdata, 16'h005A);
    chk("mixed_rv", rvalid, 1'b1);
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'h10, 16'h0000);
    chk("mixed_lane1_kept", rdata, 16'hA55A);

    // random traffic, half of it concentrated on a few addresses
    for (int i = 0; i < 400; i++) begin
      rc  = 2'($urandom);
      rw  = 2'($urandom);
      ro  = 1'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      rwd = 16'($urandom);
      cyc(1'b1, rc, rw, ro, ra, rwd);
    end

`ifdef LANE_RAM_PARITY_EN
    // corrupt one stored bit behind the parity bit's back
    cyc(1'b1, 2'b11, 2'b11, 1'b0, 8'h33, 16'h0011);
    dut.mem[0][8'h33] = 8'h10;
    rst_n = 1'b1; cs = 2'b11; we = 2'b00; oe = 1'b1; a = 8'h33; wdata = '0;
    @(posedge clk);
    #1;
    chk("perr_flip", perr, 1'b1);
    chk("perr_rdata", rdata, 16'h0010);
    exp_rdata = 16'h0010;
    mm[8'h33] = 16'h0010;
    cyc(1'b1, 2'b11, 2'b11, 1'b0, 8'h33, 16'h0011);
`endif

    // reset in IDLE wipes a freshly written word
    cyc(1'b1, 2'b11, 2'b11, 1'b0, 8'hFF, 16'h1234);
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'hFF, 16'h0000);
    chk("pre_reset_ff", rdata, 16'h1234);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 16'h0000);
    chk("rst_idle_rdata", rdata, 16'h0000);
    wait_clear(n);
    chk("reclear_len", n, 256);
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 8'hFF, 16'h0000);
    chk("reclear_ff", rdata, 16'h0000);
    chk("reclear_rv", rvalid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
